// File: rtl/rc5_enc_core_if.sv
// ---------------------------------------------------------------------------
// rc5_enc_core_if : handshake / bus bundle for the RC5-16/R engine.
//
// Signals (named from the core's point of view):
//   s_we_i, s_addr_i, s_data_i     S-table write port
//   in_valid_i, in_ready_o,
//   in_data_i                      plaintext/ciphertext block in ({B,A})
//   out_valid_o, out_ready_i,
//   out_data_o                     result block out ({B,A})
//   busy_o                         engine not idle
//   mode_i                         0=encrypt, 1=decrypt (only with RC5_DECRYPT_EN)
//
// Modports: master drives the core, slave is the core itself.
// Optional macro: RC5_DECRYPT_EN adds mode_i.
// ---------------------------------------------------------------------------
interface rc5_enc_core_if #(
    parameter int W = 16,
    parameter int R = 12
);
    localparam int AW = $clog2(2*R + 2);

    logic          s_we_i;
    logic [AW-1:0] s_addr_i;
    logic [W-1:0]  s_data_i;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [2*W-1:0] in_data_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [2*W-1:0] out_data_o;
    logic          busy_o;
`ifdef RC5_DECRYPT_EN
    logic          mode_i;

    modport master (
        output s_we_i, s_addr_i, s_data_i, in_valid_i, in_data_i, out_ready_i, mode_i,
        input  in_ready_o, out_valid_o, out_data_o, busy_o
    );

    modport slave (
        input  s_we_i, s_addr_i, s_data_i, in_valid_i, in_data_i, out_ready_i, mode_i,
        output in_ready_o, out_valid_o, out_data_o, busy_o
    );
`else
    modport master (
        output s_we_i, s_addr_i, s_data_i, in_valid_i, in_data_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_data_o, busy_o
    );

    modport slave (
        input  s_we_i, s_addr_i, s_data_i, in_valid_i, in_data_i, out_ready_i,
        output in_ready_o, out_valid_o, out_data_o, busy_o
    );
`endif
endinterface

// File: rtl/rc5_enc_core.sv
// ---------------------------------------------------------------------------
// rc5_enc_core : iterative RC5-16/R block cipher, one half-round per cycle.
//
// Contains rotl16, the 16-bit left-rotate stage (amount not reduced mod 16),
// and the engine itself, which uses two rotl16 instances.
//
// Ports of rc5_enc_core:
//   clk_i   rising-edge clock
//   rst_ni  asynchronous active-low reset
//   bus     rc5_enc_core_if.slave (S-table writes, in/out handshakes, busy)
//
// Optional macro: RC5_DECRYPT_EN adds decryption selected by bus.mode_i.
// ---------------------------------------------------------------------------
module rotl16 (
    input  logic [15:0] data_i,
    input  logic [15:0] n_i,
    output logic [15:0] data_o
);
    // Rotating the doubled word keeps amounts 0..16 exact; larger amounts
    // are not folded back, which the caller must respect.
    assign data_o = 16'(({data_i, data_i} << n_i) >> 16);
endmodule

module rc5_enc_core #(
    parameter int W = 16,
    parameter int R = 12
) (
    input logic           clk_i,
    input logic           rst_ni,
    rc5_enc_core_if.slave bus
);
    localparam int          DEPTH   = 2*R + 2;
    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
    localparam logic [7:0]  R_L     = 8'(R);

    typedef enum logic [2:0] {
        IDLE, PRE, RND, DONE
`ifdef RC5_DECRYPT_EN
        , POST
`endif
    } state_t;

    state_t         state_q;
    logic [W-1:0]   a_q, b_q, a_d, b_d;
    logic [7:0]     round_q;
    logic           half_q;
    logic           inReady_q, outValid_q, busy_q;
`ifdef RC5_DECRYPT_EN
    logic           mode_q;
`endif
    logic [W-1:0]   sTable [0:DEPTH-1];

    logic [AW-1:0]  idxEven, idxOdd;
    logic [W-1:0]   sEven, sOdd;
    logic [W-1:0]   rot0In, rot0N, rot0Out, rot1In, rot1N, rot1Out;
    logic           accept;

    assign accept  = inReady_q && bus.in_valid_i;
    assign idxEven = AW'({round_q, 1'b0});
    assign idxOdd  = AW'({round_q, 1'b1});
    assign sEven   = sTable[idxEven];
    assign sOdd    = sTable[idxOdd];

    // Key table: writable only while idle, out-of-range indices dropped.
    // Not reset, so it survives an abort.
    always_ff @(posedge clk_i) begin
        if (bus.s_we_i && state_q == IDLE && ({1'b0, bus.s_addr_i} < DEPTH_L))
            sTable[bus.s_addr_i] <= bus.s_data_i;
    end

    // Rotator inputs. Only the low 4 bits of the amount word are used; a
    // right rotate by n is a left rotate by 16-n (16 acts as identity).
    always_comb begin
        rot0In = a_q ^ b_q;
        rot0N  = {{(W-4){1'b0}}, b_q[3:0]};
        rot1In = b_q ^ a_q;
        rot1N  = {{(W-4){1'b0}}, a_q[3:0]};
`ifdef RC5_DECRYPT_EN
        if (mode_q) begin
            rot0In = b_q - sOdd;
            rot0N  = W'(16) - {{(W-4){1'b0}}, a_q[3:0]};
            rot1In = a_q - sEven;
            rot1N  = W'(16) - {{(W-4){1'b0}}, b_q[3:0]};
        end
`endif
    end

    rotl16 uRot0 (.data_i(rot0In), .n_i(rot0N), .data_o(rot0Out));
    rotl16 uRot1 (.data_i(rot1In), .n_i(rot1N), .data_o(rot1Out));

    // Next A/B for every state; the FSM simply registers them.
    always_comb begin
        a_d = a_q;
        b_d = b_q;
        case (state_q)
            IDLE: if (accept) begin
                a_d = bus.in_data_i[W-1:0];
                b_d = bus.in_data_i[2*W-1:W];
            end
            PRE: begin
                a_d = a_q + sTable[0];
                b_d = b_q + sTable[1];
            end
            RND: begin
`ifdef RC5_DECRYPT_EN
                if (mode_q) begin
                    if (!half_q) b_d = rot0Out ^ a_q;
                    else         a_d = rot1Out ^ b_q;
                end else
`endif
                begin
                    if (!half_q) a_d = rot0Out + sEven;
                    else         b_d = rot1Out + sOdd;
                end
            end
`ifdef RC5_DECRYPT_EN
            POST: begin
                a_d = a_q - sTable[0];
                b_d = b_q - sTable[1];
            end
`endif
            default: ;
        endcase
    end

    // Control FSM with registered handshake outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            round_q    <= '0;
            half_q     <= 1'b0;
            inReady_q  <= 1'b1;
            outValid_q <= 1'b0;
            busy_q     <= 1'b0;
`ifdef RC5_DECRYPT_EN
            mode_q     <= 1'b0;
`endif
        end else begin
            a_q <= a_d;
            b_q <= b_d;
            case (state_q)
                IDLE: if (accept) begin
                    half_q    <= 1'b0;
                    inReady_q <= 1'b0;
                    busy_q    <= 1'b1;
`ifdef RC5_DECRYPT_EN
                    mode_q    <= bus.mode_i;
                    if (bus.mode_i) begin
                        round_q <= R_L;
                        state_q <= RND;
                    end else
`endif
                    begin
                        round_q <= 8'd1;
                        state_q <= PRE;
                    end
                end
                PRE: state_q <= RND;
                RND: begin
                    half_q <= ~half_q;
                    if (half_q) begin
`ifdef RC5_DECRYPT_EN
                        if (mode_q) begin
                            if (round_q == 8'd1) state_q <= POST;
                            else                 round_q <= round_q - 8'd1;
                        end else
`endif
                        if (round_q == R_L) begin
                            state_q    <= DONE;
                            outValid_q <= 1'b1;
                        end else begin
                            round_q <= round_q + 8'd1;
                        end
                    end
                end
`ifdef RC5_DECRYPT_EN
                POST: begin
                    state_q    <= DONE;
                    outValid_q <= 1'b1;
                end
`endif
                DONE: if (bus.out_ready_i) begin
                    state_q    <= IDLE;
                    outValid_q <= 1'b0;
                    inReady_q  <= 1'b1;
                    busy_q     <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready_o  = inReady_q;
    assign bus.out_valid_o = outValid_q;
    assign bus.out_data_o  = {b_q, a_q};
    assign bus.busy_o      = busy_q;
endmodule

// File: doc/rc5_enc_core.md
Name: rc5_enc_core

Overview:
Iterative RC5-16/R block-cipher engine. Holds the expanded key table S[0..2R+1] in local registers and processes one 32-bit block at a time with valid/ready handshakes. Each cycle it performs one half-round using two instances of the existing 16-bit left-rotate stage. It is the direct consumer of that rotator: it drives data_i and n_i and adds the S word to data_o.

Parameters:
W, 16, word width in bits; fixed at 16 to match the rotator. Block width is 2W.
R, 12, number of rounds (1..255). S table depth is 2R+2.

Ports:
clk_i  input  1  clock, rising edge
rst_ni  input  1  asynchronous active-low reset
s_we_i  input  1  S-table write strobe
s_addr_i  input  $clog2(2R+2)  S-table write index
s_data_i  input  W  S-table write data
in_valid_i  input  1  plaintext valid
in_ready_o  output  1  core can accept a block
in_data_i  input  2W  block; [W-1:0]=A, [2W-1:W]=B
out_valid_o  output  1  result valid
out_ready_i  input  1  downstream accepts result
out_data_o  output  2W  result; [W-1:0]=A, [2W-1:W]=B
busy_o  output  1  state is not IDLE

Behaviour:
- Reset (async, rst_ni=0): state=IDLE, A/B/round counter=0, out_valid_o=0, out_data_o=0, busy_o=0, in_ready_o=1. S table is not reset (contents undefined until written).
- FSM states: IDLE, PRE, RND, DONE.
- IDLE:
  - in_ready_o=1.
  - On in_valid_i&&in_ready_o: latch A/B, set i=1 and half=0, go to PRE.
- PRE (1 cycle): A<=A+S[0], B<=B+S[1] (mod 2^W). Go to RND.
- RND (2R cycles, one half-round per cycle):
  - half=0: A <= rotl(A^B, B[3:0]) + S[2i].
  - half=1: B <= rotl(B^A, A[3:0]) + S[2i+1].
  - After half=1: i++. After the half=1 step with i=R, go to DONE.
- Rotate amount: the rotator does not reduce n_i modulo W, so the core drives n_i = {12'b0, X[3:0]}. The full word is never passed. Amount 0 must yield the input unchanged.
- All additions wrap mod 2^16. No carry out.
- DONE:
  - out_valid_o=1 and out_data_o={B,A}, held stable until out_ready_i.
  - On out_valid_o&&out_ready_i, go to IDLE at the next edge.
  - in_ready_o=0 in DONE, so accept and emit never coincide.
- Latency: accept at edge k; out_valid_o first high in the cycle after edge k+2R+1 (2R+2 cycles; 26 for R=12). Throughput is one block per 2R+3 cycles when out_ready_i=1.
- S writes: accepted only in IDLE. When busy_o=1, s_we_i is ignored (the table is unchanged). s_addr_i >= 2R+2 is ignored.
- Simultaneous s_we_i and in accept in IDLE: the write lands at the same edge. The new block uses the updated table (S[0] is read in PRE, one cycle later).
- Reset mid-operation: immediate abort to the reset values above. No partial result is emitted.
- in_valid_i is ignored outside IDLE. in_data_i is sampled only at the accept edge.

Optional Feature:
RC5_DECRYPT_EN:
- Defined:
  - Adds input port mode_i (1 bit, 0=encrypt, 1=decrypt), sampled at accept.
  - Decrypt runs RND first, with i=R down to 1:
    - half=0: B <= rotr(B-S[2i+1], A[3:0]) ^ A.
    - half=1: A <= rotr(A-S[2i], B[3:0]) ^ B.
  - Then POST (replaces PRE): B<=B-S[1], A<=A-S[0].
  - rotr(x,n) is implemented as rotl(x, 16-n) for n in 0..15.
  - Latency is identical to encrypt.
- Undefined: no mode_i port; encrypt only.

Test Plan:
1. R=12, all S=0, in_data=0x0000_0000 -> out_data=0x0000_0000; out_valid rises exactly 26 cycles after accept.
2. R=1, all S=0, in_data=0x0000_0001 -> out_data=0x0002_0001 (A=1, B=rotl(1,1)=2).
3. R=1, S0=0x0005, S1=0x0003, S2=S3=0, in_data=0 -> out_data=0x0033_0030. This checks that the rotate amount 0x30 is masked to 0.
4. Backpressure: hold out_ready_i=0 for 5 cycles in DONE -> out_data/out_valid stable, in_ready_o=0. Raise out_ready_i -> IDLE next cycle, in_ready_o=1.
5. Write S0=0xFFFF with busy_o=1 -> ignored; the next block's result matches the old table. Pull rst_ni low mid-RND -> out_valid_o=0 and in_ready_o=1 immediately.
6. With RC5_DECRYPT_EN: R=1, S as in test 3, mode_i=1, in_data=0x0033_0030 -> out_data=0x0000_0000.
